// File: rtl/simon_datapath.sv
// -----------------------------------------------------------------------------
// simon_datapath
//
// Datapath responder for the Simon Says control FSM. It generates the pulse
// timing tick, builds a 32-entry colour sequence from a free-running Galois
// LFSR, checks player moves against the stored sequence, and drives the four
// colour LEDs.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   rst_seedgen    clears the seed counter (and the fail indication)
//   start          loads the LFSR from the seed counter, restarts the timer,
//                  clears the fail indication
//   load_colour    appends the current LFSR colour at mem[current_round]
//   load_speed     latches speed and restarts the timer
//   speed[2:0]     speed level 0..7 (period = BASE_TICKS >> speed)
//   flash_clk      LED display enable
//   check_round    segments remaining, counted down by the FSM
//   current_round  rounds completed / sequence length
//   player_input   one-hot player buttons
//   pulse          single-cycle timing tick (registered)
//   result         registered move match
//   led_out        registered colour LED drive
// -----------------------------------------------------------------------------
module simon_datapath #(
    parameter int unsigned BASE_TICKS   = 25000000,
    parameter int unsigned MIN_TICKS    = 1000000,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rst_seedgen,
    input  logic       start,
    input  logic       load_colour,
    input  logic       load_speed,
    input  logic [2:0] speed,
    input  logic       flash_clk,
    input  logic [5:0] check_round,
    input  logic [5:0] current_round,
    input  logic [3:0] player_input,
    output logic       pulse,
    output logic       result,
    output logic [3:0] led_out
);

    localparam logic [31:0] BASE_TICKS_W = 32'(BASE_TICKS);
    localparam logic [31:0] MIN_TICKS_W  = 32'(MIN_TICKS);
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    // One Galois step: shift right, fold the mask in when a one falls out.
    // A zero state maps to zero, so an unloaded LFSR stays idle.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        logic [15:0] nxt;
        nxt = {1'b0, state[15:1]};
        if (state[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Two LFSR bits select one of the four one-hot colours.
    function automatic logic [3:0] encode_colour(input logic [1:0] sel);
        logic [3:0] colour;
        case (sel)
            2'd0:    colour = 4'b0001;
            2'd1:    colour = 4'b0010;
            2'd2:    colour = 4'b0100;
            2'd3:    colour = 4'b1000;
            default: colour = 4'b0000;
        endcase
        return colour;
    endfunction

    // Internal state
    logic [15:0] seed_cnt_r;
    logic [15:0] lfsr_r;
    logic [2:0]  spd_r;
    logic [31:0] tick_cnt_r;
    logic        pulse_r;
    logic        result_r;
    logic        fail_mode_r;
    logic [3:0]  last_input_r;
    logic [3:0]  led_r;
    logic [3:0]  mem_r [0:31];

    // Combinational helpers
    logic [15:0] seed_val_s;
    logic [15:0] lfsr_load_s;
    logic [3:0]  colour_s;
    logic [4:0]  addr_s;
    logic [3:0]  rd_data_s;
    logic [31:0] base_shift_s;
    logic [31:0] period_s;
    logic        timer_restart_s;
    logic        match_s;
    logic        miss_s;
    logic        unused_ok_s;

    // Only five address bits matter; the segment address wraps mod 32.
    assign unused_ok_s = check_round[5];

    // Seed counter free-runs so the sequence depends on when start arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_cnt_r <= 16'h0000;
        end else if (rst_seedgen) begin
            seed_cnt_r <= 16'h0000;
        end else begin
            seed_cnt_r <= seed_cnt_r + 16'h0001;
        end
    end

    // Seed selection: a same-cycle rst_seedgen counts as a zero seed, and a
    // zero seed would lock the LFSR, so it is replaced by DEFAULT_SEED.
    always_comb begin
        seed_val_s  = seed_cnt_r;
        lfsr_load_s = DEFAULT_SEED;
        if (rst_seedgen) begin
            seed_val_s = 16'h0000;
        end else begin
            seed_val_s = seed_cnt_r;
        end
        if (seed_val_s == 16'h0000) begin
            lfsr_load_s = DEFAULT_SEED;
        end else begin
            lfsr_load_s = seed_val_s;
        end
    end

    // LFSR: load on start, otherwise advance every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= 16'h0000;
        end else if (start) begin
            lfsr_r <= lfsr_load_s;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // The colour written uses the LFSR value before any same-cycle load.
    assign colour_s = encode_colour(lfsr_r[1:0]);

    // Sequence memory write; rounds beyond 31 are silently dropped. No reset
    // so stale entries simply get overwritten as rounds are re-added.
    always_ff @(posedge clk) begin
        if (load_colour && (current_round < 6'd32)) begin
            mem_r[current_round[4:0]] <= colour_s;
        end else begin
            mem_r[current_round[4:0]] <= mem_r[current_round[4:0]];
        end
    end

    // Segment being replayed/checked: oldest first as check_round counts down.
    assign addr_s    = current_round[4:0] - check_round[4:0];
    assign rd_data_s = mem_r[addr_s];

    // Speed register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spd_r <= 3'd0;
        end else if (load_speed) begin
            spd_r <= speed;
        end else begin
            spd_r <= spd_r;
        end
    end

    // Pulse period with a floor so high speeds stay playable.
    assign base_shift_s = BASE_TICKS_W >> spd_r;

    // Period selection.
    always_comb begin
        period_s = base_shift_s;
        if (base_shift_s < MIN_TICKS_W) begin
            period_s = MIN_TICKS_W;
        end else begin
            period_s = base_shift_s;
        end
    end

    assign timer_restart_s = start | load_speed;

    // Tick counter and pulse: pulse is registered, so it appears the cycle
    // after the counter sits at period-1. The >= also recovers cleanly if the
    // counter is ever beyond a newly shortened period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= 32'd0;
            pulse_r    <= 1'b0;
        end else if (timer_restart_s) begin
            tick_cnt_r <= 32'd0;
            pulse_r    <= 1'b0;
        end else if (tick_cnt_r >= (period_s - 32'd1)) begin
            tick_cnt_r <= 32'd0;
            pulse_r    <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + 32'd1;
            pulse_r    <= 1'b0;
        end
    end

    // Move comparison: a multi-hot press never equals a one-hot colour, and
    // an idle (zero) input is neither a match nor a miss.
    always_comb begin
        match_s = 1'b0;
        miss_s  = 1'b0;
        if (player_input != 4'b0000) begin
            match_s = (player_input == rd_data_s);
            miss_s  = (player_input != rd_data_s);
        end else begin
            match_s = 1'b0;
            miss_s  = 1'b0;
        end
    end

    // Move result, last pressed buttons and sticky fail indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r     <= 1'b0;
            last_input_r <= 4'b0000;
            fail_mode_r  <= 1'b0;
        end else begin
            result_r <= match_s;
            if (player_input != 4'b0000) begin
                last_input_r <= player_input;
            end else begin
                last_input_r <= last_input_r;
            end
            if (start || rst_seedgen) begin
                fail_mode_r <= 1'b0;
            end else if (miss_s) begin
                fail_mode_r <= 1'b1;
            end else begin
                fail_mode_r <= fail_mode_r;
            end
        end
    end

    // LED drive: after a miss, show the wrong buttons instead of the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r <= 4'b0000;
        end else if (!flash_clk) begin
            led_r <= 4'b0000;
        end else if (fail_mode_r) begin
            led_r <= last_input_r;
        end else begin
            led_r <= rd_data_s;
        end
    end

    assign pulse   = pulse_r;
    assign result  = result_r;
    assign led_out = led_r;

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
- Datapath responder to the Simon Says control FSM.
- It consumes the FSM control strobes (rst_seedgen, start, load_colour, load_speed, flash_clk, speed, check_round, current_round) and player buttons.
- It returns the `pulse` timing tick and the `result` move-check bit.
- It holds the 32-entry colour sequence produced by an LFSR and drives the four colour LEDs.

Parameters:
- BASE_TICKS, 25000000: pulse period in clk cycles at speed 0.
- MIN_TICKS, 1000000: floor on the pulse period at high speeds.
- DEFAULT_SEED, 16'hACE1: LFSR seed used when the captured seed is zero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- rst_seedgen  in  1  clears the seed counter
- start  in  1  loads the LFSR from the seed counter and restarts the pulse timer
- load_colour  in  1  appends one colour to the sequence
- load_speed  in  1  latches `speed`
- speed  in  3  speed level 0..7
- flash_clk  in  1  LED display enable
- check_round  in  6  segments remaining (FSM down-counter)
- current_round  in  6  rounds completed / sequence length
- player_input  in  4  one-hot player buttons
- pulse  out  1  single-cycle timing tick
- result  out  1  registered move match
- led_out  out  4  colour LED drive

Behaviour:
- Reset (async) clears:
  - pulse=0, result=0, led_out=0.
  - Seed counter, LFSR, speed register, tick counter, fail_mode and last_input all = 0.
  - Sequence memory is not reset.
- Seed counter (16 b):
  - Increments every cycle and wraps at 16'hFFFF→0.
  - rst_seedgen forces it to 0 (rst_seedgen wins over increment).
- LFSR (16 b Galois, mask 16'hB400):
  - On start: load the seed counter value, or DEFAULT_SEED if that value is 0.
  - Otherwise it shifts every cycle once loaded; an unloaded LFSR (0) stays 0.
- Colour encoding from lfsr[1:0]: 0→0001, 1→0010, 2→0100, 3→1000.
- Sequence memory: 32×4.
  - On load_colour with current_round<32: mem[current_round[4:0]] <= encoded colour in the same cycle.
  - On load_colour with current_round>=32: write ignored.
- Segment address: addr = (current_round − check_round) mod 32, 5-bit. It is valid when 1<=check_round<=current_round; otherwise the memory read is don't-care.
- Speed: spd_reg <= speed on load_speed. It is held otherwise, and speed is ignored when load_speed=0.
- Pulse timer:
  - period = max(BASE_TICKS >> spd_reg, MIN_TICKS).
  - tick counter counts 0..period−1; pulse=1 for exactly the one cycle after the counter reaches period−1, then the counter returns to 0.
  - start or load_speed clears the counter (no pulse that cycle). The new period applies from the next cycle.
  - Pulse runs continuously from reset.
- Result:
  - result <= (player_input != 0) && (player_input == mem[addr]) each cycle, i.e. 1-cycle latency.
  - Multi-hot or zero input gives result=0.
- last_input <= player_input whenever player_input != 0.
- fail_mode:
  - Set on the cycle after a sample where player_input != 0 and result would be 0.
  - Cleared by start or rst_seedgen; clear has priority.
- LED output (registered, 1-cycle latency):
  - led_out <= flash_clk ? (fail_mode ? last_input : mem[addr]) : 4'b0000.
- Simultaneous events:
  - start+load_colour: the write uses the pre-load LFSR value.
  - rst_seedgen+start: the LFSR loads DEFAULT_SEED.
- Reset mid-operation: all outputs drop to reset values immediately (async). The memory keeps stale data, which is overwritten as rounds are re-added.

Test Plan:
- Seed capture and LFSR load:
  - Stimulus: reset, pulse rst_seedgen, wait exactly 10 cycles, pulse start.
  - Required response: LFSR = 16'h000A.
  - Also: start on the rst_seedgen cycle → LFSR = 16'hACE1.
- Sequence write/read (BASE_TICKS=64, MIN_TICKS=4):
  - Stimulus: load_colour at current_round=0,1,2 with the LFSR forced so lfsr[1:0]=2,0,3.
  - Stimulus: with current_round=3, step check_round 3,2,1 and assert flash_clk.
  - Required response: led_out = 0100, 0001, 1000, each one cycle late.
- Pulse rate:
  - speed 0 → pulse every 64 cycles.
  - load_speed with speed=2 → first pulse 16 cycles later, then every 16.
  - speed=6 → period floors to 4.
  - Pulse width is always 1 cycle.
- Move check (current_round=2, mem = {0010, 0100}, check_round=2):
  - player_input=0010 → result=1 next cycle.
  - player_input=0110 → result=0, and fail_mode then set.
  - With flash_clk=1 → led_out=0110 (last_input).
  - start clears fail_mode.
- Overflow and reset:
  - load_colour at current_round=32 → mem[0] unchanged.
  - Assert reset while pulse/led_out are active → both are 0 within the same cycle, before the next clk edge.
